// File: rtl/vram_arbiter.sv
// vram_arbiter
// Owns the single-port frame buffer. Active-video cycles always go to display
// refresh; blanking cycles drain the CPU posted-write FIFO first, then serve a
// pending CPU read. Reads are therefore ordered behind every queued write.
//
// Ports
//   pixel_clock, reset        clock, asynchronous active-high reset
//   blank_i, x_i, y_i         timing core (blank_i = 0 -> active video)
//   pix_data_o, pix_valid_o   pixel to DAC, 3 cycles after the slot decision
//   cpu_req_i/we_i/addr_i/wdata_i, cpu_ack_o, cpu_rdata_o   CPU bus bridge
//   mem_en_o/we_o/addr_o/wdata_o, mem_rdata_i               frame buffer RAM
module vram_arbiter #(
  parameter int unsigned ADDR_W      = 19,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned H_ACTIVE    = 640,
  parameter int unsigned WFIFO_DEPTH = 4
) (
  input  logic              pixel_clock,
  input  logic              reset,
  input  logic              blank_i,
  input  logic [10:0]       x_i,
  input  logic [10:0]       y_i,
  output logic [DATA_W-1:0] pix_data_o,
  output logic              pix_valid_o,
  input  logic              cpu_req_i,
  input  logic              cpu_we_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [DATA_W-1:0] cpu_wdata_i,
  output logic              cpu_ack_o,
  output logic [DATA_W-1:0] cpu_rdata_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  localparam int unsigned PTR_W = (WFIFO_DEPTH > 2) ? $clog2(WFIFO_DEPTH) : 1;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wentry_t;

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_ISSUE, R_CAPT} rstate_t;

  // ---------------------------------------------------------------------------
  // Display address: y*H_ACTIVE + x, arithmetic modulo 2^ADDR_W
  // ---------------------------------------------------------------------------
  logic [ADDR_W-1:0] x_a, y_a, lin_addr;
  assign x_a = ADDR_W'(x_i);
  assign y_a = ADDR_W'(y_i);

  generate
    if (H_ACTIVE == 640) begin : g_shift
      assign lin_addr = (y_a << 9) + (y_a << 7) + x_a;
    end else begin : g_mul
      assign lin_addr = y_a * ADDR_W'(H_ACTIVE) + x_a;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Posted-write FIFO; pointers carry one wrap bit to tell full from empty
  // ---------------------------------------------------------------------------
  wentry_t          fifo_q [WFIFO_DEPTH];
  logic [PTR_W:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic             fifo_empty, fifo_full, fifo_push, fifo_pop;
  wentry_t          fifo_head;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                      (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign fifo_head  = fifo_q[rd_ptr_q[PTR_W-1:0]];

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  rstate_t           rstate_q, rstate_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              cpu_ack_q, cpu_ack_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic              mem_en_q, mem_en_d, mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] pix_data_q;
  logic [2:0]        vld_pipe_q;   // !blank delayed 1..3 cycles
  logic              disp_slot, wr_slot, rd_slot, idle;

  assign idle      = (rstate_q == R_IDLE);
  assign disp_slot = ~blank_i;
  assign wr_slot   = blank_i & ~fifo_empty;
  assign rd_slot   = blank_i & fifo_empty & (rstate_q == R_WAIT);

  // A cycle carrying cpu_ack ignores cpu_req so a held request is not taken
  // twice; a pop in the same cycle does not open a slot for a full FIFO.
  assign fifo_push = cpu_req_i & cpu_we_i & ~fifo_full & ~cpu_ack_q & idle;
  assign fifo_pop  = wr_slot;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    rstate_d    = rstate_q;
    rd_addr_d   = rd_addr_q;
    cpu_rdata_d = cpu_rdata_q;
    cpu_ack_d   = fifo_push;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = '0;
    mem_wdata_d = '0;

    if (fifo_push) wr_ptr_d = wr_ptr_q + (PTR_W+1)'(1);
    if (fifo_pop)  rd_ptr_d = rd_ptr_q + (PTR_W+1)'(1);

    // slot decision
    if (disp_slot) begin
      mem_en_d   = 1'b1;
      mem_addr_d = lin_addr;
    end else if (wr_slot) begin
      mem_en_d    = 1'b1;
      mem_we_d    = 1'b1;
      mem_addr_d  = fifo_head.addr;
      mem_wdata_d = fifo_head.data;
    end else if (rd_slot) begin
      mem_en_d   = 1'b1;
      mem_addr_d = rd_addr_q;
    end

    // read FSM
    unique case (rstate_q)
      R_IDLE: if (cpu_req_i & ~cpu_we_i & ~cpu_ack_q) begin
        rstate_d  = R_WAIT;
        rd_addr_d = cpu_addr_i;
      end
      R_WAIT:  if (rd_slot) rstate_d = R_ISSUE;
      R_ISSUE: rstate_d = R_CAPT;
      R_CAPT: begin
        cpu_rdata_d = mem_rdata_i;
        cpu_ack_d   = 1'b1;
        rstate_d    = R_IDLE;
      end
      default: rstate_d = R_IDLE;
    endcase
  end

  always_ff @(posedge pixel_clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      rstate_q    <= R_IDLE;
      rd_addr_q   <= '0;
      cpu_ack_q   <= 1'b0;
      cpu_rdata_q <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      pix_data_q  <= '0;
      vld_pipe_q  <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      rstate_q    <= rstate_d;
      rd_addr_q   <= rd_addr_d;
      cpu_ack_q   <= cpu_ack_d;
      cpu_rdata_q <= cpu_rdata_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      // vld_pipe_q[1] marks the cycle in which display read data is on mem_rdata
      pix_data_q  <= vld_pipe_q[1] ? mem_rdata_i : '0;
      vld_pipe_q  <= {vld_pipe_q[1:0], ~blank_i};
    end
  end

  // FIFO storage needs no reset; the pointers define what is valid.
  always_ff @(posedge pixel_clock) begin
    if (fifo_push) fifo_q[wr_ptr_q[PTR_W-1:0]] <= '{addr: cpu_addr_i, data: cpu_wdata_i};
  end

  assign pix_data_o  = pix_data_q;
  assign pix_valid_o = vld_pipe_q[2];
  assign cpu_ack_o   = cpu_ack_q;
  assign cpu_rdata_o = cpu_rdata_q;
  assign mem_en_o    = mem_en_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;

endmodule

// File: tb/tb_vram_arbiter.sv
module tb_vram_arbiter;

  logic        pixel_clock = 1'b0;
  logic        reset = 1'b1;
  logic        blank = 1'b1;
  logic [10:0] x = '0, y = '0;
  logic [7:0]  pix_data;
  logic        pix_valid;
  logic        cpu_req = 1'b0, cpu_we = 1'b0;
  logic [18:0] cpu_addr = '0;
  logic [7:0]  cpu_wdata = '0;
  logic        cpu_ack;
  logic [7:0]  cpu_rdata;
  logic        mem_en, mem_we;
  logic [18:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata = '0;

  vram_arbiter dut (
    .pixel_clock(pixel_clock), .reset(reset), .blank_i(blank), .x_i(x), .y_i(y),
    .pix_data_o(pix_data), .pix_valid_o(pix_valid),
    .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr), .cpu_wdata_i(cpu_wdata),
    .cpu_ack_o(cpu_ack), .cpu_rdata_o(cpu_rdata),
    .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_rdata_i(mem_rdata)
  );

  always #5 pixel_clock = ~pixel_clock;

  // synchronous RAM model
  logic [7:0] ram [0:524287];
  always @(posedge pixel_clock) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata <= ram[mem_addr];
    end
  end

  // bus monitor
  int cyc = 0, last_wr_cyc = -1, last_rd_cyc = -1, ack_cyc = -1;
  int we_cnt = 0, en_cnt = 0, ack_cnt = 0;
  logic [26:0] wlog [$];
  always @(posedge pixel_clock) begin
    if (mem_en && mem_we) begin wlog.push_back({mem_addr, mem_wdata}); last_wr_cyc = cyc; we_cnt++; end
    if (mem_en && !mem_we) last_rd_cyc = cyc;
    if (mem_en) en_cnt++;
    if (cpu_ack) begin ack_cyc = cyc; ack_cnt++; end
    cyc++;
  end

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge pixel_clock);
    #1;
  endtask

  // Drives one request, waits (bounded) for ack, drops req, idles one cycle.
  // lat = cycles from the request cycle to the ack cycle, -1 on timeout.
  task automatic cpu_access(input logic we, input logic [18:0] a, input logic [7:0] d,
                            input int bound, output int lat);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
    lat = 0;
    do begin tick(); lat++; end while (!cpu_ack && lat < bound);
    if (!cpu_ack) lat = -1;
    cpu_req = 1'b0;
    tick();
  endtask

  function automatic logic [31:0] all_outs();
    return {31'd0, |{pix_data, pix_valid, cpu_ack, cpu_rdata, mem_en, mem_we, mem_addr, mem_wdata}};
  endfunction

  typedef struct {
    logic [10:0] vx, vy;
    logic [7:0]  data;
    logic [18:0] exp_addr;
  } disp_vec_t;

  disp_vec_t dv [6];

  initial begin
    int lat, ack0, we0, en0, hits;
    dv[0] = '{11'd5,    11'd2,    8'hA5, 19'd1285};
    dv[1] = '{11'd0,    11'd0,    8'h11, 19'd0};
    dv[2] = '{11'd639,  11'd479,  8'h22, 19'd307199};
    dv[3] = '{11'd10,   11'd1,    8'h33, 19'd650};
    dv[4] = '{11'd100,  11'd100,  8'h5E, 19'd64100};
    dv[5] = '{11'd2047, 11'd2047, 8'h77, 19'd263551};  // wraps modulo 2^19

    // reset state
    tick(); tick();
    chk("reset_outputs_zero", all_outs(), 32'd0);
    reset = 1'b0;
    tick(); tick();
    chk("idle_no_mem_en", {31'd0, mem_en}, 32'd0);

    // display fetch table
    for (int i = 0; i < 6; i++) begin
      ram[dv[i].exp_addr] = dv[i].data;
      blank = 1'b0; x = dv[i].vx; y = dv[i].vy;
      tick();
      chk($sformatf("disp%0d_addr", i), {13'd0, mem_addr}, {13'd0, dv[i].exp_addr});
      chk($sformatf("disp%0d_en_nowe", i), {30'd0, mem_en, mem_we}, 32'd2);
      blank = 1'b1;
      tick(); tick();
      chk($sformatf("disp%0d_pix", i), {24'd0, pix_data}, {24'd0, dv[i].data});
      chk($sformatf("disp%0d_valid", i), {31'd0, pix_valid}, 32'd1);
      tick();
      chk($sformatf("disp%0d_valid_drop", i), {31'd0, pix_valid}, 32'd0);
    end

    // minimum read latency in blanking with empty FIFO
    cpu_access(1'b0, 19'd1285, 8'h00, 20, lat);
    chk("rd_min_latency", lat, 32'd4);
    chk("rd_data", {24'd0, cpu_rdata}, 32'hA5);

    // read after write to the same address
    cpu_access(1'b1, 19'd100, 8'h3C, 20, lat);
    chk("raw_wr_ack_latency", lat, 32'd1);
    cpu_access(1'b0, 19'd100, 8'h00, 20, lat);
    chk("raw_rd_latency", lat, 32'd4);
    chk("raw_rdata", {24'd0, cpu_rdata}, 32'h3C);
    chk("raw_ack_after_grant", ack_cyc - last_rd_cyc, 32'd2);
    chk("raw_write_before_read", {31'd0, last_wr_cyc < last_rd_cyc}, 32'd1);
    tick(); tick();
    chk("rdata_held", {24'd0, cpu_rdata}, 32'h3C);

    // FIFO full during an active line
    wlog.delete();
    blank = 1'b0; x = 11'd0; y = 11'd3;
    for (int k = 0; k < 4; k++) begin
      cpu_access(1'b1, 19'(200 + k), 8'(8'h10 + k), 4, lat);
      chk($sformatf("full_wr%0d_ack", k), lat, 32'd1);
    end
    ack0 = ack_cnt; we0 = we_cnt;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 19'd204; cpu_wdata = 8'h14;
    repeat (630) tick();
    chk("full_fifth_no_ack", ack_cnt - ack0, 32'd0);
    chk("full_no_we_active", we_cnt - we0, 32'd0);
    blank = 1'b1;
    lat = 0;
    do begin tick(); lat++; end while (!cpu_ack && lat < 20);
    if (!cpu_ack) lat = -1;
    chk("full_fifth_ack_after_blank", lat, 32'd2);
    cpu_req = 1'b0;
    repeat (8) tick();
    chk("full_write_count", wlog.size(), 32'd5);
    for (int k = 0; k < 5; k++) begin
      if (k < wlog.size())
        chk($sformatf("full_order%0d", k), {5'd0, wlog[k]}, {5'd0, 19'(200 + k), 8'(8'h10 + k)});
    end

    // read issued at the start of an active line
    blank = 1'b0; x = 11'd0; y = 11'd5;
    ack0 = ack_cnt; hits = 0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 19'd64100;
    for (int k = 0; k < 640; k++) begin
      tick();
      x = 11'(k + 1);
      if (mem_en && mem_addr == 19'd64100) hits++;
    end
    chk("active_rd_no_cpu_slot", hits, 32'd0);
    chk("active_rd_no_ack", ack_cnt - ack0, 32'd0);
    blank = 1'b1;
    lat = 0;
    do begin tick(); lat++; end while (!cpu_ack && lat < 20);
    if (!cpu_ack) lat = -1;
    chk("active_rd_ack_after_blank", lat, 32'd3);
    chk("active_rd_data", {24'd0, cpu_rdata}, 32'h5E);
    cpu_req = 1'b0;
    tick();

    // reset mid-operation: 3 queued writes and a pending read
    blank = 1'b0; x = 11'd7; y = 11'd9;
    for (int k = 0; k < 3; k++) begin
      cpu_access(1'b1, 19'(300 + k), 8'(8'h40 + k), 4, lat);
      chk($sformatf("rst_wr%0d_ack", k), lat, 32'd1);
    end
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 19'd1285;
    tick(); tick();
    chk("pre_rst_active", {30'd0, pix_valid, mem_en}, 32'd3);
    reset = 1'b1; cpu_req = 1'b0;
    #1;
    chk("midop_reset_outputs_zero", all_outs(), 32'd0);
    tick(); tick();
    reset = 1'b0; blank = 1'b1;
    we0 = we_cnt; ack0 = ack_cnt; en0 = en_cnt;
    repeat (8) tick();
    chk("post_rst_no_we", we_cnt - we0, 32'd0);
    chk("post_rst_no_ack", ack_cnt - ack0, 32'd0);
    chk("post_rst_no_en", en_cnt - en0, 32'd0);
    cpu_access(1'b0, 19'd650, 8'h00, 20, lat);
    chk("post_rst_rd_latency", lat, 32'd4);
    chk("post_rst_rd_data", {24'd0, cpu_rdata}, 32'h33);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
